// File: rtl/iomem_arbiter_if.sv
// iomem bus bundle: valid/ready handshake with byte strobes, address,
// write data and read data.
//   master modport : drives valid/wstrb/addr/wdata, receives ready/rdata
//   slave  modport : receives valid/wstrb/addr/wdata, drives ready/rdata
interface iomem_arbiter_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
  modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_arbiter.sv
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last_owner, last_nxt;
  logic        own_valid;
  logic        expire;
  logic        done;
  logic [31:0] resp_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
    end
  end

  assign own_valid = owner ? m1_valid : m0_valid;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn)            cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else if (!s_ready)      cnt <= cnt + 16'd1;
  end

  assign expire     = (state == BUSY) && own_valid && !s_ready && (cnt == CNT_LAST);
  assign resp_rdata = expire ? TIMEOUT_RDATA : s_rdata;
`else
  assign expire     = 1'b0;
  assign resp_rdata = s_rdata;
`endif

  assign timeout_err = expire;
  assign done        = s_ready | expire;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    grant     = 2'b00;
    s_valid   = 1'b0;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nxt = BUSY;
          if (m0_valid && m1_valid) owner_nxt = ~last_owner;
          else                      owner_nxt = m1_valid;
        end
      end
      BUSY: begin
        grant   = owner ? 2'b10 : 2'b01;
        s_valid = own_valid & ~expire;
        s_wstrb = owner ? m1_wstrb : m0_wstrb;
        s_addr  = owner ? m1_addr  : m0_addr;
        s_wdata = owner ? m1_wdata : m0_wdata;
        if (owner) begin
          m1_ready = done;
          m1_rdata = resp_rdata;
        end else begin
          m0_ready = done;
          m0_rdata = resp_rdata;
        end
        if (done) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else if (!own_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
module tb_iomem_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        m0_valid, m0_ready;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_valid, m1_ready;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  iomem_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic        v;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
  } mreq_t;

  typedef struct {
    logic        rst;
    mreq_t       q0, q1;
    logic        sr;
    logic [31:0] srd;
    logic [1:0]  g;
    mreq_t       es;
    logic        m0r;
    logic [31:0] m0rd;
    logic        m1r;
    logic [31:0] m1rd;
  } vec_t;

  localparam mreq_t NONE = '0;
  localparam mreq_t R0 = '{v:1'b1, w:4'h0, a:32'h0300_0000, d:32'h0};
  localparam mreq_t W0 = '{v:1'b1, w:4'hF, a:32'h0300_0004, d:32'h11};
  localparam mreq_t W1 = '{v:1'b1, w:4'hF, a:32'h0300_0008, d:32'h22};
  localparam mreq_t F0 = '{v:1'b1, w:4'h0, a:32'h0300_0010, d:32'h0};
  localparam mreq_t F1 = '{v:1'b1, w:4'h3, a:32'h0300_0014, d:32'hA5A5};

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, mreq_t q0, mreq_t q1, logic sr, logic [31:0] srd,
                              logic [1:0] g, mreq_t es, logic m0r, logic [31:0] m0rd,
                              logic m1r, logic [31:0] m1rd);
    vec_t v;
    v.rst = r; v.q0 = q0; v.q1 = q1; v.sr = sr; v.srd = srd;
    v.g = g; v.es = es; v.m0r = m0r; v.m0rd = m0rd; v.m1r = m1r; v.m1rd = m1rd;
    return v;
  endfunction

  task automatic drive(logic r, mreq_t q0, mreq_t q1, logic sr, logic [31:0] srd);
    resetn = r;
    m0_valid = q0.v; m0_wstrb = q0.w; m0_addr = q0.a; m0_wdata = q0.d;
    m1_valid = q1.v; m1_wstrb = q1.w; m1_addr = q1.a; m1_wdata = q1.d;
    s_ready = sr; s_rdata = srd;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_vec(int i, vec_t v);
    mreq_t sbus;
    sbus = '{v:s_valid, w:s_wstrb, a:s_addr, d:s_wdata};
    checks++;
    if (grant !== v.g || sbus !== v.es || m0_ready !== v.m0r || m0_rdata !== v.m0rd ||
        m1_ready !== v.m1r || m1_rdata !== v.m1rd || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL vec%0d: got g=%b s=%h m0=%b/%h m1=%b/%h te=%b want g=%b s=%h m0=%b/%h m1=%b/%h te=0",
               i, grant, sbus, m0_ready, m0_rdata, m1_ready, m1_rdata, timeout_err,
               v.g, v.es, v.m0r, v.m0rd, v.m1r, v.m1rd);
    end
  endtask

  task automatic cyc(logic r, mreq_t q0, mreq_t q1, logic sr, logic [31:0] srd);
    @(negedge clk);
    drive(r, q0, q1, sr, srd);
    #1;
  endtask

  initial begin
    drive(1'b0, NONE, NONE, 1'b0, 32'h0);

    tbl.push_back(mk(1, R0,   NONE, 0, 0,  2'b00, NONE, 0, 0, 0, 0));
    tbl.push_back(mk(1, R0,   NONE, 0, 0,  2'b01, R0,   0, 0, 0, 0));
    tbl.push_back(mk(1, R0,   NONE, 0, 0,  2'b01, R0,   0, 0, 0, 0));
    tbl.push_back(mk(1, R0,   NONE, 1, 5,  2'b01, R0,   1, 5, 0, 0));
    tbl.push_back(mk(1, NONE, NONE, 0, 0,  2'b00, NONE, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE, NONE, 0, 0,  2'b00, NONE, 0, 0, 0, 0));
    tbl.push_back(mk(1, W0,   W1,   0, 0,  2'b00, NONE, 0, 0, 0, 0));
    tbl.push_back(mk(1, W0,   W1,   0, 0,  2'b01, W0,   0, 0, 0, 0));
    tbl.push_back(mk(1, W0,   W1,   1, 32'h77, 2'b01, W0, 1, 32'h77, 0, 0));
    tbl.push_back(mk(1, NONE, W1,   0, 0,  2'b00, NONE, 0, 0, 0, 0));
    tbl.push_back(mk(1, NONE, W1,   0, 0,  2'b10, W1,   0, 0, 0, 0));
    tbl.push_back(mk(1, NONE, W1,   1, 32'h77, 2'b10, W1, 0, 0, 1, 32'h77));
    tbl.push_back(mk(1, NONE, NONE, 0, 0,  2'b00, NONE, 0, 0, 0, 0));
    for (int t = 0; t < 6; t++) begin
      tbl.push_back(mk(1, F0, F1, 0, 0, 2'b00, NONE, 0, 0, 0, 0));
      if (t % 2 == 0)
        tbl.push_back(mk(1, F0, F1, 1, 32'h100 + t, 2'b01, F0, 1, 32'h100 + t, 0, 0));
      else
        tbl.push_back(mk(1, F0, F1, 1, 32'h100 + t, 2'b10, F1, 0, 0, 1, 32'h100 + t));
    end
    tbl.push_back(mk(1, NONE, NONE, 0, 0, 2'b00, NONE, 0, 0, 0, 0));

    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_svalid", 32'(s_valid), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_ready", 32'({m0_ready, m1_ready}), 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].q0, tbl[i].q1, tbl[i].sr, tbl[i].srd);
      #1;
      check_vec(i, tbl[i]);
    end

    cyc(1, R0, NONE, 0, 0);      chk("mb_idle_grant", 32'(grant), 0);
    cyc(1, R0, NONE, 0, 0);      chk("mb_busy_grant", 32'(grant), 32'b01);
    cyc(0, R0, NONE, 0, 0);      chk("mb_rst_ready", 32'(m0_ready), 0);
    cyc(1, R0, NONE, 0, 0);
    chk("mb_after_svalid", 32'(s_valid), 0);
    chk("mb_after_grant", 32'(grant), 0);
    chk("mb_after_ready", 32'({m0_ready, m1_ready}), 0);
    cyc(1, R0, NONE, 0, 0);      chk("mb_reissue_addr", s_addr, 32'h0300_0000);
    cyc(1, R0, NONE, 1, 32'h9);
    chk("mb_reissue_ready", 32'(m0_ready), 1);
    chk("mb_reissue_rdata", m0_rdata, 32'h9);
    cyc(1, NONE, NONE, 0, 0);    chk("mb_end_grant", 32'(grant), 0);

    cyc(1, NONE, F1, 0, 0);
    cyc(1, NONE, F1, 0, 0);      chk("pv_grant", 32'(grant), 32'b10);
    cyc(1, NONE, NONE, 0, 0);
    chk("pv_svalid", 32'(s_valid), 0);
    chk("pv_ready", 32'(m1_ready), 0);
    cyc(1, NONE, NONE, 0, 0);    chk("pv_idle", 32'(grant), 0);
    cyc(1, F0, F1, 0, 0);
    cyc(1, F0, F1, 0, 0);        chk("pv_tie_m1", 32'(grant), 32'b10);
    cyc(1, F0, F1, 1, 32'h3);    chk("pv_m1_ready", 32'(m1_ready), 1);
    cyc(0, NONE, NONE, 0, 0);

`ifdef IOMEM_ARB_TIMEOUT_EN
    cyc(1, NONE, F1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, NONE, F1, 0, 0);
      if (k < 8) begin
        chk($sformatf("to_wait%0d", k), 32'({s_valid, m1_ready, timeout_err}), 32'b100);
      end else begin
        chk("to_ready", 32'({s_valid, m1_ready, timeout_err}), 32'b011);
        chk("to_rdata", m1_rdata, 32'hDEAD_BEEF);
      end
    end
    cyc(1, NONE, NONE, 0, 0);
    chk("to_after", 32'({s_valid, timeout_err, grant}), 0);
    cyc(1, NONE, F1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) begin
        cyc(1, NONE, F1, 0, 0);
        chk($sformatf("tr_wait%0d", k), 32'({m1_ready, timeout_err}), 0);
      end else begin
        cyc(1, NONE, F1, 1, 32'h1234);
        chk("tr_ready", 32'({m1_ready, timeout_err}), 32'b10);
        chk("tr_rdata", m1_rdata, 32'h1234);
      end
    end
    cyc(1, NONE, NONE, 0, 0);
    chk("tr_after", 32'({timeout_err, grant}), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got no finish want finish");
    $fatal(1);
  end
endmodule
